// File: rtl/aes_axis_blk_tx_pkg.sv
// Shared AES stream definitions: block/word/byte sizes, transmit FSM states and the
// per-word byte swap reused by both the input packer and the output serializer.
package aes_axis_blk_tx_pkg;

   localparam int BLK_S  = 128;
   localparam int WORD_S = 32;
   localparam int BYTE_S = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } tx_state_e;

   // The core emits words big-endian; the driver reads them little-endian.
   function automatic logic [WORD_S-1:0] swap_bytes32(input logic [WORD_S-1:0] w);
      logic [WORD_S-1:0] r;
      r = '0;
      for (int i = 0; i < WORD_S / BYTE_S; i++) begin
         r[i*BYTE_S +: BYTE_S] = w[WORD_S-BYTE_S-i*BYTE_S +: BYTE_S];
      end
      return r;
   endfunction

endpackage

// File: rtl/aes_blk_fifo.sv
// Synchronous block FIFO with registered occupancy count; full/empty derive from the
// count only, so ready never depends on the same-cycle pop.
module aes_blk_fifo #(
   parameter int WIDTH = 129,
   parameter int DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       wr_en_i,
   input  logic [WIDTH-1:0]           wr_data_i,
   input  logic                       rd_en_i,
   output logic [WIDTH-1:0]           rd_data_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_wr, do_rd;

   assign full_o    = (count_q == (AW+1)'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign count_o   = count_q;
   assign do_wr     = wr_en_i && !full_o;
   assign do_rd     = rd_en_i && !empty_o;
   assign rd_data_o = mem_q[rd_ptr_q];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_wr, do_rd})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage is not reset; the pointers alone define what is valid.
   always_ff @(posedge clk_i) begin
      if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
   end

endmodule

// File: rtl/aes_axis_blk_tx.sv
// Buffers 128-bit result blocks and serializes each into four byte-swapped 32-bit
// AXI-Stream beats, asserting tlast on the final beat of a packet's last block.
module aes_axis_blk_tx
   import aes_axis_blk_tx_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int BLK_W      = BLK_S,
   parameter int WORD_W     = WORD_S
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic [0:BLK_W-1]  blk_in,
   input  logic              blk_in_last,
   input  logic              blk_in_valid,
   output logic              blk_in_ready,
   output logic [WORD_W-1:0] m_axis_tdata,
   output logic              m_axis_tvalid,
   output logic              m_axis_tlast,
   input  logic              m_axis_tready
);

   localparam int BEATS = BLK_W / WORD_W;
   localparam int CNT_W = $clog2(BEATS);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

   tx_state_e             state_q, state_d;
   logic [BLK_W-1:0]      sr_q;
   logic                  last_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [BLK_W:0]        head;
   logic                  fifo_full, fifo_empty, pop, hs;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;

   aes_blk_fifo #(
      .WIDTH (BLK_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i     (aclk),
      .rst_ni    (aresetn),
      .wr_en_i   (blk_in_valid),
      .wr_data_i ({blk_in, blk_in_last}),
      .rd_en_i   (pop),
      .rd_data_o (head),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .count_o   (fifo_count)
   );

   assign blk_in_ready = !fifo_full;
   assign hs           = m_axis_tvalid && m_axis_tready;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // A pop on the final beat reloads the shift register so blocks stream without a bubble.
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            if (hs && cnt_q == LAST_CNT) begin
               if (!fifo_empty) pop = 1'b1;
               else             state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      m_axis_tvalid = (state_q == ST_SEND);
      m_axis_tdata  = m_axis_tvalid ? swap_bytes32(sr_q[BLK_W-1 -: WORD_W]) : '0;
      m_axis_tlast  = m_axis_tvalid && last_q && (cnt_q == LAST_CNT);
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         sr_q   <= '0;
         last_q <= 1'b0;
         cnt_q  <= '0;
      end else if (pop) begin
         sr_q   <= head[BLK_W:1];
         last_q <= head[0];
         cnt_q  <= '0;
      end else if (hs) begin
         sr_q   <= sr_q << WORD_W;
         cnt_q  <= cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_aes_axis_blk_tx.sv
// Directed and randomized checks of the block-to-beat serializer against a queue model
// built from the block/beat/byte-order rules.
module tb_aes_axis_blk_tx;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic [0:127] blk_in;
  logic         blk_in_last, blk_in_valid, blk_in_ready;
  logic [31:0]  m_axis_tdata;
  logic         m_axis_tvalid, m_axis_tlast, m_axis_tready;

  int checks = 0;
  int errors = 0;
  int hs_total = 0;
  int step_no = 0;
  logic [32:0] exp_q[$];
  logic [32:0] obs_log[$];
  int          hs_step[$];
  logic        held = 1'b0;
  logic [32:0] held_beat = '0;

  always #5 aclk = ~aclk;

  aes_axis_blk_tx dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .blk_in        (blk_in),
    .blk_in_last   (blk_in_last),
    .blk_in_valid  (blk_in_valid),
    .blk_in_ready  (blk_in_ready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready)
  );

  function automatic logic [31:0] ref_swap(input logic [31:0] w);
    ref_swap = {<<8{w}};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs at the falling edge, then sample and update the model.
  task automatic step(input logic v, input logic [127:0] b, input logic l,
                      input logic rdy, output logic acc);
    @(negedge aclk);
    blk_in_valid  = v;
    blk_in        = b;
    blk_in_last   = l;
    m_axis_tready = rdy;
    #1;
    if (held) begin
      chk("hold_valid", m_axis_tvalid, 1'b1);
      chk("hold_beat", {m_axis_tlast, m_axis_tdata}, held_beat);
    end
    acc = v && blk_in_ready;
    if (acc) begin
      for (int k = 0; k < 4; k++)
        exp_q.push_back({l && (k == 3), ref_swap(b[127-32*k -: 32])});
    end
    if (m_axis_tvalid && rdy) begin
      obs_log.push_back({m_axis_tlast, m_axis_tdata});
      hs_step.push_back(step_no);
      hs_total++;
      if (exp_q.size() == 0) chk("spurious_beat", {m_axis_tlast, m_axis_tdata}, 64'hdead);
      else chk("beat", {m_axis_tlast, m_axis_tdata}, exp_q.pop_front());
    end
    held      = m_axis_tvalid && !rdy;
    held_beat = {m_axis_tlast, m_axis_tdata};
    step_no++;
  endtask

  task automatic drain(input bit osc, input int bound);
    logic a;
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && n < bound) begin
      step(1'b0, '0, 1'b0, osc ? ((step_no % 8) >= 2) : 1'b1, a);
      n++;
    end
    chk("drain_done", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic a;
    int base, n, acc_n;
    logic [127:0] blk1, blk2, blks[6];

    blk1 = 128'h29c3505f_571420f6_402299b3_1a02d73a;
    blk2 = 128'h2914b146_6013ba1e_48d6d795_e97d3e15;

    // reset state
    aresetn = 1'b0; blk_in = '0; blk_in_last = 0; blk_in_valid = 0; m_axis_tready = 0;
    repeat (3) @(negedge aclk);
    #1;
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_ready", blk_in_ready, 1);
    @(negedge aclk);
    aresetn = 1'b1;

    // single block, latency and byte order
    base = obs_log.size();
    step(1, blk1, 1, 1, a);
    chk("t1_accept", a, 1);
    step(0, '0, 0, 1, a);
    chk("t1_valid_n1", m_axis_tvalid, 0);
    step(0, '0, 0, 1, a);
    chk("t1_valid_n2", m_axis_tvalid, 1);
    drain(0, 50);
    chk("t1_b0", obs_log[base],   33'h0_5f50c329);
    chk("t1_b1", obs_log[base+1], 33'h0_f6201457);
    chk("t1_b2", obs_log[base+2], 33'h0_b3992240);
    chk("t1_b3", obs_log[base+3], 33'h1_3ad7021a);

    // two blocks back to back
    base = obs_log.size();
    step(1, blk1, 0, 1, a);
    step(1, blk2, 1, 1, a);
    drain(0, 50);
    chk("t2_beats", obs_log.size() - base, 8);
    chk("t2_nobubble", hs_step[base+7] - hs_step[base], 7);
    chk("t2_mid", obs_log[base+3], 33'h0_3ad7021a);
    chk("t2_last", obs_log[base+7], 33'h1_153e7de9);

    // tready oscillating 2 low / 6 high, random blocks and input gaps
    base = hs_total;
    for (int i = 0; i < 4; i++) begin
      blks[i] = {$urandom, $urandom, $urandom, $urandom};
      n = 0;
      a = 0;
      while (!a && n < 40) begin
        step($urandom_range(0, 1), blks[i], i == 3, (step_no % 8) >= 2, a);
        n++;
      end
      chk("t3_accept", a, 1);
    end
    drain(1, 200);
    chk("t3_beats", hs_total - base, 16);

    // backpressure until full
    base = hs_total;
    for (int i = 0; i < 6; i++) blks[i] = {$urandom, $urandom, $urandom, $urandom};
    acc_n = 0;
    for (int i = 0; i < 12; i++) begin
      step(1, blks[acc_n], acc_n == 4, 0, a);
      if (a) acc_n++;
    end
    chk("t4_accepted", acc_n, 5);
    chk("t4_ready_low", blk_in_ready, 0);
    drain(0, 200);
    chk("t4_beats", hs_total - base, 20);
    chk("t4_ready_back", blk_in_ready, 1);

    // reset after beat 2 with another block buffered
    step(1, {$urandom, $urandom, $urandom, $urandom}, 0, 1, a);
    step(1, {$urandom, $urandom, $urandom, $urandom}, 1, 1, a);
    base = hs_total;
    n = 0;
    while (hs_total - base < 2 && n < 20) begin
      step(0, '0, 0, 1, a);
      n++;
    end
    chk("t5_two_beats", hs_total - base, 2);
    aresetn = 1'b0;
    #1;
    chk("t5_tvalid", m_axis_tvalid, 0);
    chk("t5_tlast", m_axis_tlast, 0);
    chk("t5_tdata", m_axis_tdata, 0);
    chk("t5_ready", blk_in_ready, 1);
    exp_q.delete();
    held = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    base = obs_log.size();
    step(1, blk2, 1, 1, a);
    drain(0, 50);
    chk("t5_beats", obs_log.size() - base, 4);
    chk("t5_first", obs_log[base], 33'h0_46b11429);

    // write coinciding with pop while FIFO holds depth-1
    acc_n = 0;
    for (int i = 0; i < 4; i++) begin
      step(1, {$urandom, $urandom, $urandom, $urandom}, 0, 0, a);
      if (a) acc_n++;
    end
    chk("t6_filled", acc_n, 4);
    step(0, '0, 0, 0, a);
    chk("t6_ready_pre", blk_in_ready, 1);
    for (int i = 0; i < 3; i++) step(0, '0, 0, 1, a);
    step(1, {$urandom, $urandom, $urandom, $urandom}, 1, 1, a);
    chk("t6_accept", a, 1);
    step(0, '0, 0, 0, a);
    chk("t6_ready_post", blk_in_ready, 1);
    drain(0, 200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_axis_blk_tx.md
Name: aes_axis_blk_tx

Overview:
- Output side of the AES AXI-Stream accelerator: accepts 128-bit result blocks from the AES core and streams them to the AXI-Stream master port as four 32-bit beats per block.
- Buffers up to FIFO_DEPTH blocks so the core does not stall on downstream tready gaps (tready can oscillate, e.g. 2 low / 6 high cycles).
- Converts each word to the little-endian byte order the kernel driver expects, and marks packet end with tlast.

Parameters:
- FIFO_DEPTH, 4, number of 128-bit blocks buffered; power of 2, at least 2.
- BLK_W, 128, block width; equals `BLK_S from aes.vh.
- WORD_W, 32, AXI-Stream tdata width; equals `WORD_S.

Ports:
- aclk  in  1  single clock; all logic rising-edge.
- aresetn  in  1  asynchronous active-low reset.
- blk_in  in  BLK_W  result block, bit 0 = MSB, word 0 = bits [0:31].
- blk_in_last  in  1  block is the final block of the current packet.
- blk_in_valid  in  1  blk_in/blk_in_last valid.
- blk_in_ready  out  1  FIFO can accept a block.
- m_axis_tdata  out  WORD_W  output beat.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tlast  out  1  last beat of packet.
- m_axis_tready  in  1  downstream ready.

Behaviour:
- Reset (async assert, sync release): FIFO empty, word counter 0, state IDLE, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, blk_in_ready=1.
- Input handshake: a write occurs when blk_in_valid && blk_in_ready. blk_in_ready = !full (registered count-based). A write stores {blk_in, blk_in_last}.
- Full condition: a simultaneous write and FIFO pop in the same cycle keeps the count unchanged. When the FIFO is full, blk_in_ready stays 0 in that cycle even if a pop occurs, so there is no combinational ready path.
- FSM:
  - IDLE: if FIFO is non-empty, load the head block into the shift register, pop it, set cnt=0, and go to SEND.
  - SEND: m_axis_tvalid=1. On each beat handshake (tvalid && tready), cnt++.
  - On the handshake with cnt==3: if the FIFO is non-empty, load the next block in the same cycle, pop it, set cnt=0, and stay in SEND (back-to-back, no bubble). Otherwise go to IDLE.
- Latency: a block written to an empty FIFO in cycle N produces its first beat valid in cycle N+2 (write at N, IDLE load at N+1, tvalid at N+2).
- tdata: beat k (k=0..3) = swap_bytes32(block[k*32 +: 32]), i.e. byte order reversed within each word.
  - Example: word 0x29c3505f is output as tdata=0x5f50c329.
- tlast: asserted only on beat k==3 of a block stored with blk_in_last=1; 0 on all other beats.
- AXI-Stream rules:
  - Once tvalid=1, tdata/tlast/tvalid hold stable until tready.
  - tvalid never deasserts without a handshake.
  - tvalid does not depend combinationally on tready.
- tready low for any duration: the beat is held; the FIFO keeps filling until full, then blk_in_ready=0.
- Reset mid-packet: the partially sent block and all buffered blocks are discarded; outputs return to reset values immediately.
- Pointers: log2(FIFO_DEPTH) bits, wrap naturally; count is log2(FIFO_DEPTH)+1 bits.

Decomposition:
- Shared defines `BLK_S, `WORD_S, `BYTE_S come from aes.vh.
- A swap_bytes32 function lives in a shared AES include/package so the input-side packer reuses it.
- One sub-module: aes_blk_fifo (synchronous FIFO, width BLK_W+1, depth FIFO_DEPTH, with full/empty/count).
- The FSM, word counter and output mux stay in aes_axis_blk_tx.

Test Plan:
- Single block 0x29c3505f_571420f6_402299b3_1a02d73a, last=1, tready held 1 -> beats 0x5f50c329, 0xf6201457, 0xb3992240, 0x3ad7021a; tlast only on the 4th; first tvalid 2 cycles after the write.
- Two blocks (second = 0x2914b146_6013ba1e_48d6d795_e97d3e15, last only on second), tready=1 -> 8 consecutive beats with no bubble; tlast only on beat 8 (0x153e7de9).
- tready oscillating 2 low/6 high over 4 blocks -> all 16 words in order; tdata stable while tready=0; zero words lost or duplicated.
- tready=0 while writing FIFO_DEPTH+1 blocks -> blk_in_ready drops after the 4th buffered block (one block is in the shift register, so 5 are accepted); releasing tready drains all 20 beats in order.
- aresetn pulsed low after beat 2 of a block -> tvalid=0 asynchronously, blk_in_ready=1; a following new block streams from beat 0 with correct data.
- Simultaneous write and pop with FIFO at FIFO_DEPTH-1 -> count unchanged, no overflow, and ordering preserved.
